// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Purpose  : Seven-segment encodings and BCD sizing helper for the display.
// Revision : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low patterns, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int bcd_digit_count(input int data_w);
        return (data_w + 2) / 3 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_ctrl_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter, one iteration per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import hex_display_pkg::*;
#(
    parameter int DATA_W     = 18,
    parameter int BCD_DIGITS = bcd_digit_count(DATA_W)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [DATA_W-1:0]       i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int c_CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic                    w_load;
    logic                    w_step;
    logic [DATA_W-1:0]       r_shift;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_bcd_adj;
    logic [c_CNT_W-1:0]      r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= c_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            c_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = (DATA_W == 1) ? c_DONE : c_SHIFT;
                end
            end
            c_SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == c_CNT_W'(DATA_W - 1)) w_state_next = c_DONE;
            end
            c_DONE: begin
                o_done       = 1'b1;
                w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    // The load edge already performs the first iteration, since add-3 on an
    // all-zero BCD register is a no-op; the result is ready one cycle early.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_bcd   <= {{(4*BCD_DIGITS-1){1'b0}}, i_bin[DATA_W-1]};
            r_shift <= i_bin << 1;
            r_cnt   <= c_CNT_W'(1);
        end else if (w_step) begin
            r_bcd   <= {w_bcd_adj[4*BCD_DIGITS-2:0], r_shift[DATA_W-1]};
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_bcd = r_bcd;

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Purpose  : Multi-digit seven-segment driver, hex or decimal, with blanking.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int DATA_W     = 18,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    mode,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int c_BCD_DIGITS = bcd_digit_count(DATA_W);
    localparam int c_DIG_W      = 4 * NUM_DIGITS;
    localparam int c_BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic                              w_accept;
    logic                              w_conv_start;
    logic                              w_conv_busy;
    logic                              w_conv_done;
    logic                              w_take_bcd;
    logic [4*c_BCD_DIGITS-1:0]         w_conv_bcd;
    logic [c_DIG_W+4*c_BCD_DIGITS-1:0] w_bcd_wide;
    logic [c_DIG_W+4*c_BCD_DIGITS-1:0] w_bcd_hi;
    logic [c_DIG_W+DATA_W-1:0]         w_hex_wide;
    logic [c_DIG_W+DATA_W-1:0]         w_hex_hi;
    logic [c_DIG_W-1:0]                r_digits;
    logic [c_DIG_W-1:0]                w_src_digits;
    logic                              r_dig_ovf;
    logic                              w_src_ovf;
    logic                              r_mode;
    logic                              r_overflow;
    logic [c_BLINK_W-1:0]              r_blink_cnt;
    logic                              r_blink_off;
    logic                              w_phase_off;
    logic [7*NUM_DIGITS-1:0]           r_hex_out;
    logic [7*NUM_DIGITS-1:0]           w_hex_next;
    logic                              w_zero_run;
    logic [3:0]                        w_nib;
    logic [6:0]                        w_seg;

    assign w_accept     = wr_en && !w_conv_busy;
    assign w_conv_start = w_accept && mode;
    assign w_take_bcd   = w_conv_done && r_mode;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (c_BCD_DIGITS)
    ) u_bin2bcd (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_start (w_conv_start),
        .i_bin   (wr_data),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    // Zero-extend before splitting so any digit count / width mix is legal.
    assign w_bcd_wide = {{c_DIG_W{1'b0}}, w_conv_bcd};
    assign w_bcd_hi   = w_bcd_wide >> c_DIG_W;
    assign w_hex_wide = {{c_DIG_W{1'b0}}, wr_data};
    assign w_hex_hi   = w_hex_wide >> c_DIG_W;

    // A finished conversion bypasses the digit store so the display and
    // overflow change on the same edge that busy falls.
    assign w_src_digits = w_take_bcd ? w_bcd_wide[c_DIG_W-1:0] : r_digits;
    assign w_src_ovf    = w_take_bcd ? (|w_bcd_hi) : r_dig_ovf;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_digits  <= '0;
            r_dig_ovf <= 1'b0;
            r_mode    <= 1'b0;
        end else if (w_accept) begin
            r_mode <= mode;
            if (!mode) begin
                r_digits  <= w_hex_wide[c_DIG_W-1:0];
                r_dig_ovf <= |w_hex_hi;
            end
        end else if (w_take_bcd) begin
            r_digits  <= w_src_digits;
            r_dig_ovf <= w_src_ovf;
        end
    end

    assign w_phase_off = blink_en && r_blink_off;

    always_comb begin
        w_hex_next = '1;
        w_zero_run = 1'b1;
        w_nib      = '0;
        w_seg      = SEG_BLANK;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nib      = w_src_digits[4*i +: 4];
            w_zero_run = w_zero_run && (w_nib == 4'd0);
            if (w_phase_off)                           w_seg = SEG_BLANK;
            else if (w_src_ovf)                        w_seg = SEG_DASH;
            else if (lz_blank && w_zero_run && i != 0) w_seg = SEG_BLANK;
            else                                       w_seg = SEG_TABLE[w_nib];
            w_hex_next[7*i +: 7] = w_seg;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_hex_out   <= '1;
            r_overflow  <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            r_hex_out  <= w_hex_next;
            r_overflow <= w_src_ovf;
            if (!blink_en) begin
                r_blink_cnt <= '0;
                r_blink_off <= 1'b0;
            end else if (r_blink_cnt == c_BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
            end
        end
    end

    assign busy     = w_conv_busy;
    assign overflow = r_overflow;
    assign hex_out  = r_hex_out;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_ctrl
// Purpose  : Randomized scoreboard bench for hex_display_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

    localparam int c_ND = 5;
    localparam int c_DW = 18;
    localparam int c_BD = 4;
    localparam int c_HW = 7 * c_ND;

    logic            clk_clk = 1'b0;
    logic            reset_reset_n;
    logic            wr_en;
    logic [c_DW-1:0] wr_data;
    logic            mode;
    logic            lz_blank;
    logic            blink_en;
    logic            busy;
    logic            overflow;
    logic [c_HW-1:0] hex_out;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    int              q_cyc[$];
    logic [c_HW-1:0] q_hex[$];
    bit              q_ovf[$];
    bit              q_busy[$];
    string           q_name[$];

    int cur_val;
    bit cur_dec;

    hex_display_ctrl #(
        .NUM_DIGITS (c_ND),
        .DATA_W     (c_DW),
        .BLINK_DIV  (c_BD)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .mode          (mode),
        .lz_blank      (lz_blank),
        .blink_en      (blink_en),
        .busy          (busy),
        .overflow      (overflow),
        .hex_out       (hex_out)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        repeat (n) r = r * 10;
        return r;
    endfunction

    function automatic bit model_ovf(input int v, input bit dec);
        return dec ? (v >= pow10(c_ND)) : (v >= (1 << (4 * c_ND)));
    endfunction

    function automatic logic [c_HW-1:0] render(input int v, input bit dec, input bit lz, input bit off);
        int              d[c_ND];
        int              top;
        logic [c_HW-1:0] r;
        top = 0;
        for (int i = 0; i < c_ND; i++) begin
            d[i] = dec ? (v / pow10(i)) % 10 : (v >> (4 * i)) & 15;
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < c_ND; i++) begin
            if (off)                   r[7*i +: 7] = 7'h7F;
            else if (model_ovf(v, dec)) r[7*i +: 7] = 7'h3F;
            else if (lz && i > top)    r[7*i +: 7] = 7'h7F;
            else                       r[7*i +: 7] = seg7(d[i]);
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic push(input int c, input logic [c_HW-1:0] h, input bit o, input bit b, input string n);
        q_cyc.push_back(c);
        q_hex.push_back(h);
        q_ovf.push_back(o);
        q_busy.push_back(b);
        q_name.push_back(n);
    endtask

    initial begin
        forever begin
            @(negedge clk_clk);
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                checks++;
                if (q_cyc[0] < cyc) begin
                    errors++;
                    $display("FAIL %s stale expectation for cycle %0d seen at cycle %0d", q_name[0], q_cyc[0], cyc);
                end else if (hex_out !== q_hex[0] || overflow !== q_ovf[0] || busy !== q_busy[0]) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got hex_out=%h overflow=%b busy=%b expected hex_out=%h overflow=%b busy=%b",
                             q_name[0], cyc, hex_out, overflow, busy, q_hex[0], q_ovf[0], q_busy[0]);
                end
                void'(q_cyc.pop_front());
                void'(q_hex.pop_front());
                void'(q_ovf.pop_front());
                void'(q_busy.pop_front());
                void'(q_name.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_write(input int v, input bit dec, input int inject_at, input string n);
        int              k;
        logic [c_HW-1:0] old_h;
        bit              old_o;
        k     = cyc;
        old_h = render(cur_val, cur_dec, lz_blank, 1'b0);
        old_o = model_ovf(cur_val, cur_dec);
        wr_en   = 1'b1;
        wr_data = c_DW'(v);
        mode    = dec;
        if (!dec) begin
            push(k + 1, old_h, old_o, 1'b0, {n, "_hold"});
            push(k + 2, render(v, 1'b0, lz_blank, 1'b0), model_ovf(v, 1'b0), 1'b0, n);
            tick();
            wr_en = 1'b0;
            tick();
        end else begin
            for (int j = 1; j <= c_DW; j++) push(k + j, old_h, old_o, 1'b1, {n, "_busy"});
            push(k + c_DW + 1, render(v, 1'b1, lz_blank, 1'b0), model_ovf(v, 1'b1), 1'b0, n);
            tick();
            wr_en = 1'b0;
            for (int j = 1; j <= c_DW; j++) begin
                if (j == inject_at) begin
                    wr_en   = 1'b1;
                    wr_data = c_DW'(999);
                    mode    = 1'($urandom_range(0, 1));
                end
                tick();
                wr_en = 1'b0;
            end
        end
        cur_val = v;
        cur_dec = dec;
    endtask

    task automatic set_lz(input bit b);
        lz_blank = b;
        push(cyc + 1, render(cur_val, cur_dec, b, 1'b0), model_ovf(cur_val, cur_dec), 1'b0, "lz_live");
        tick();
    endtask

    initial begin
        int              k;
        int              v;
        logic [c_HW-1:0] old_h;
        bit              old_o;

        reset_reset_n = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        mode          = 1'b0;
        lz_blank      = 1'b0;
        blink_en      = 1'b0;
        cur_val       = 0;
        cur_dec       = 1'b0;

        push(1, '1, 1'b0, 1'b0, "reset_state");
        push(2, '1, 1'b0, 1'b0, "reset_state");
        tick();
        tick();
        reset_reset_n = 1'b1;
        push(cyc + 1, render(0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, "post_reset_zero");
        tick();

        do_write(32'h0A3F5, 1'b0, 0, "hex_0A3F5");
        do_write(12345, 1'b1, 5, "dec_12345_ignore_999");
        do_write(200000, 1'b1, 0, "dec_200000_ovf");
        do_write(32'h3FFFF, 1'b0, 0, "hex_3FFFF");
        set_lz(1'b1);
        do_write(7, 1'b1, 0, "lz_dec_7");
        do_write(0, 1'b1, 0, "lz_dec_0");
        do_write(32'h00F0, 1'b0, 0, "lz_hex_F0");

        // blink: four samples shown, four blank, repeating
        k = cyc;
        blink_en = 1'b1;
        for (int j = 1; j <= 16; j++)
            push(k + j, render(cur_val, cur_dec, lz_blank, ((j - 1) / c_BD) % 2 == 1),
                 model_ovf(cur_val, cur_dec), 1'b0, "blink_phase");
        repeat (16) tick();
        k = cyc;
        blink_en = 1'b0;
        for (int j = 1; j <= 3; j++)
            push(k + j, render(cur_val, cur_dec, lz_blank, 1'b0), model_ovf(cur_val, cur_dec), 1'b0, "blink_stop");
        repeat (3) tick();

        // reset in the middle of a conversion
        k     = cyc;
        old_h = render(cur_val, cur_dec, lz_blank, 1'b0);
        old_o = model_ovf(cur_val, cur_dec);
        wr_en   = 1'b1;
        wr_data = c_DW'(54321);
        mode    = 1'b1;
        for (int j = 1; j <= 8; j++) push(k + j, old_h, old_o, 1'b1, "abort_busy");
        tick();
        wr_en = 1'b0;
        repeat (8) tick();
        reset_reset_n = 1'b0;
        push(k + 9, '1, 1'b0, 1'b0, "abort_reset");
        push(k + 10, '1, 1'b0, 1'b0, "abort_reset");
        tick();
        reset_reset_n = 1'b1;
        cur_val = 0;
        cur_dec = 1'b0;
        do_write(32'h1234, 1'b0, 0, "write_after_abort");

        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 3))
                0: do_write(int'($urandom_range(0, (1 << c_DW) - 1)), 1'b0, 0, "rand_hex");
                1: begin
                    v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (1 << c_DW) - 1))
                                                    : int'($urandom_range(0, 999));
                    do_write(v, 1'b1, int'($urandom_range(0, 17)), "rand_dec");
                end
                2: set_lz(1'($urandom_range(0, 1)));
                default: do_write(int'($urandom_range(0, 99999)), 1'b1, 0, "rand_dec_fit");
            endcase
        end

        repeat (3) tick();
        checks++;
        if (q_cyc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
